// File: rtl/sym_lane_packer.sv
// sym_lane_packer: gathers SYM_W-bit symbols into LANES-lane words (lane 0 in the
// most significant position) and queues them in a DEPTH-entry FIFO. A word is
// committed when its last lane fills or when s_last closes it early. Unfilled
// lanes are zero.
// Optional feature macro: XZ_SCRUB_EN. When defined, X/Z symbol bits are stored as 0
// and xz_seen is a sticky flag. When undefined, symbols pass through unmodified and
// xz_seen is tied low.
module sym_lane_packer #(
  parameter int unsigned LANES = 5,
  parameter int unsigned SYM_W = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SYM_W-1:0]                 s_sym,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [LANES*SYM_W-1:0]           m_word,
  output logic [$clog2(LANES+1)-1:0]       m_count,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_level,
  output logic                             xz_seen
);

  localparam int unsigned WordW = LANES * SYM_W;
  localparam int unsigned IdxW  = $clog2(LANES);
  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  // Assembler: the lane index is the state (0 = empty, otherwise partial)
  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  w_idx_d;
  logic [WordW-1:0] r_word;
  logic [WordW-1:0] w_word_d;
  logic [WordW-1:0] w_lane_word;
  logic [CntW-1:0]  w_push_cnt;

  // FIFO storage and pointers; the extra MSB is the wrap bit
  logic [WordW-1:0] r_mem_word [DEPTH];
  logic [CntW-1:0]  r_mem_cnt  [DEPTH];
  logic [PtrW:0]    r_wr_ptr;
  logic [PtrW:0]    r_rd_ptr;
  logic [PtrW:0]    w_level;

  logic [SYM_W-1:0] w_sym;
  logic             w_sym_xz;
  logic             w_accept;
  logic             w_close;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  // Symbol conditioning: optional X/Z scrub ahead of the lane mux
`ifdef XZ_SCRUB_EN
  always_comb begin
    w_sym    = s_sym;
    w_sym_xz = 1'b0;
    for (int b = 0; b < SYM_W; b++) begin
      if ($isunknown(s_sym[b])) begin
        w_sym[b] = 1'b0;
        w_sym_xz = 1'b1;
      end
    end
  end
`else
  assign w_sym    = s_sym;
  assign w_sym_xz = 1'b0;
`endif

  // Handshake decode; s_ready depends only on the FIFO level
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign fifo_level = LvlW'(w_level);
  assign s_ready    = (fifo_level != LvlW'(DEPTH));
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign m_valid    = !w_empty;
  assign w_accept   = s_valid && s_ready;
  assign w_pop      = m_valid && m_ready;
  assign w_close    = s_last || (r_idx == IdxW'(LANES - 1));

  // Assembler next state: place the symbol in its lane, commit or advance
  always_comb begin
    w_lane_word = r_word;
    for (int k = 0; k < LANES; k++) begin
      if (r_idx == IdxW'(k)) begin
        w_lane_word[(LANES-1-k)*SYM_W +: SYM_W] = w_sym;
      end
    end
    w_push_cnt = CntW'(r_idx) + CntW'(1);
    w_idx_d    = r_idx;
    w_word_d   = r_word;
    w_push     = 1'b0;
    if (w_accept) begin
      if (w_close) begin
        w_push   = 1'b1;
        w_idx_d  = '0;
        w_word_d = '0;
      end else begin
        w_idx_d  = r_idx + IdxW'(1);
        w_word_d = w_lane_word;
      end
    end
  end

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else begin
      r_idx  <= w_idx_d;
      r_word <= w_word_d;
    end
  end

  // FIFO storage and pointers; push and pop may happen on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_word[i] <= '0;
        r_mem_cnt[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_word[r_wr_ptr[PtrW-1:0]] <= w_lane_word;
        r_mem_cnt[r_wr_ptr[PtrW-1:0]]  <= w_push_cnt;
        r_wr_ptr                       <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Head read is combinational and forced to zero while the FIFO is empty
  always_comb begin
    m_word  = '0;
    m_count = '0;
    if (m_valid) begin
      m_word  = r_mem_word[r_rd_ptr[PtrW-1:0]];
      m_count = r_mem_cnt[r_rd_ptr[PtrW-1:0]];
    end
  end

`ifdef XZ_SCRUB_EN
  logic r_xz_seen;

  // Sticky unknown-symbol flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xz_seen <= 1'b0;
    end else if (w_accept && w_sym_xz) begin
      r_xz_seen <= 1'b1;
    end
  end

  assign xz_seen = r_xz_seen;
`else
  assign xz_seen = 1'b0;
`endif

endmodule

// File: tb/tb_sym_lane_packer.sv
// Directed bench for sym_lane_packer (LANES=5, SYM_W=2, DEPTH=4).
module tb_sym_lane_packer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_sym;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [9:0] m_word;
  logic [2:0] m_count;
  logic [2:0] fifo_level;
  logic       xz_seen;

  int n_checks;
  int n_errors;

  sym_lane_packer #(
    .LANES(5),
    .SYM_W(2),
    .DEPTH(4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sym     (s_sym),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_word    (m_word),
    .m_count   (m_count),
    .fifo_level(fifo_level),
    .xz_seen   (xz_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one symbol and hold it until accepted (bounded); returns 1 ns after the edge
  task automatic send(input logic [1:0] sym, input logic last);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_sym   = sym;
    s_last  = last;
    for (int c = 0; c < 50 && !done; c++) begin
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Check the head word and pop it
  task automatic pop_check(input string tag, input logic [9:0] w, input logic [2:0] c);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_word"}, {22'd0, m_word}, {22'd0, w});
    check({tag, "_count"}, {29'd0, m_count}, {29'd0, c});
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_sym    = 2'd0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    #12;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_word", {22'd0, m_word}, 32'd0);
    check("rst_m_count", {29'd0, m_count}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_xz", {31'd0, xz_seen}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word 3,2,1,0,3
    send(2'd3, 1'b0);
    send(2'd2, 1'b0);
    send(2'd1, 1'b0);
    send(2'd0, 1'b0);
    check("full_not_yet", {31'd0, m_valid}, 32'd0);
    send(2'd3, 1'b0);
    check("full_level", {29'd0, fifo_level}, 32'd1);
    pop_check("full", 10'h393, 3'd5);

    // Flush on s_last
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    send(2'd3, 1'b1);
    check("flush_level", {29'd0, fifo_level}, 32'd2);
    pop_check("flush_a", 10'h180, 3'd2);
    pop_check("flush_b", 10'h300, 3'd1);
    check("flush_empty", {31'd0, m_valid}, 32'd0);

    // Backpressure: 20 symbols fill the FIFO with four words
    for (int i = 0; i < 20; i++) send(2'(i % 4), 1'b0);
    check("bp_level_full", {29'd0, fifo_level}, 32'd4);
    check("bp_ready_low", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b1;
    s_sym   = 2'd1;
    s_last  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("bp_stall_level", {29'd0, fifo_level}, 32'd4);
    check("bp_stall_head", {22'd0, m_word}, 32'h06c);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("bp_pop_level", {29'd0, fifo_level}, 32'd3);
    check("bp_ready_rise", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("bp_21st_level", {29'd0, fifo_level}, 32'd4);
    pop_check("bp_w1", 10'h1b1, 3'd5);
    pop_check("bp_w2", 10'h2c6, 3'd5);
    pop_check("bp_w3", 10'h31b, 3'd5);
    pop_check("bp_w4", 10'h100, 3'd1);
    check("bp_drained", {29'd0, fifo_level}, 32'd0);

    // Simultaneous push and pop at level 2
    send(2'd2, 1'b1);
    send(2'd1, 1'b1);
    check("pp_level_pre", {29'd0, fifo_level}, 32'd2);
    m_ready = 1'b1;
    send(2'd3, 1'b1);
    m_ready = 1'b0;
    check("pp_level_post", {29'd0, fifo_level}, 32'd2);
    pop_check("pp_head", 10'h100, 3'd1);
    pop_check("pp_tail", 10'h300, 3'd1);

    // Known symbols never raise the unknown-symbol flag
    send(2'd1, 1'b0);
    for (int i = 0; i < 4; i++) send(2'd0, 1'b0);
    pop_check("xz_word", 10'h100, 3'd5);
    check("xz_clear", {31'd0, xz_seen}, 32'd0);

    // Asynchronous reset mid-word discards partial and queued words
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    send(2'd3, 1'b0);
    send(2'd3, 1'b0);
    send(2'd3, 1'b0);
    check("mr_level_pre", {29'd0, fifo_level}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr_m_valid", {31'd0, m_valid}, 32'd0);
    check("mr_level", {29'd0, fifo_level}, 32'd0);
    check("mr_s_ready", {31'd0, s_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(2'd1, 1'b0);
    pop_check("mr_word", 10'h155, 3'd5);
    check("mr_end_empty", {31'd0, m_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sym_lane_packer.md
# sym_lane_packer

Upstream stage that collects a stream of SYM_W-bit symbols and packs them into LANES-lane packed words. It supplies the `[0:4][4:3]` style lane buses used by the lane consumers: 5 lanes of 2 bits, with lane 0 most significant. A small FIFO with a valid/ready handshake on both sides decouples the symbol producer from the word consumer. Partial words are flushed on an end-of-burst marker.

## Interface
- LANES, 5, lanes per output word (≥2)
- SYM_W, 2, bits per symbol/lane (≥1)
- DEPTH, 4, FIFO entries, power of two, ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  symbol offered
- s_ready  output  1  symbol accepted when s_valid && s_ready at clk edge
- s_sym  input  SYM_W  symbol value
- s_last  input  1  qualifies s_sym as final symbol of burst; closes the current word
- m_valid  output  1  FIFO head word present
- m_ready  input  1  consumer takes head word when m_valid && m_ready
- m_word  output  LANES*SYM_W  packed word; lane k at bits [(LANES-1-k)*SYM_W +: SYM_W]
- m_count  output  $clog2(LANES+1)  number of filled lanes in m_word (1..LANES)
- fifo_level  output  $clog2(DEPTH+1)  words held in FIFO
- xz_seen  output  1  sticky unknown-symbol flag (see Configuration)

## Operation
- Assembler states: EMPTY (lane index 0, nothing held), PARTIAL (1..LANES-1 lanes held). The lane index is the state variable.
- Accepted symbol goes to lane = current index.
- On an accepted symbol where the index is LANES-1 or s_last=1:
  - the word is committed to the FIFO with m_count = index+1;
  - unfilled lanes are zero;
  - the assembler returns to EMPTY.
- Otherwise the index increments (EMPTY→PARTIAL, PARTIAL→PARTIAL).
- s_ready = (fifo_level != DEPTH). The conservative rule stalls even symbols that would not complete a word.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits plus a wrap bit.
  - full = pointers equal with wrap bits different; empty = pointers and wrap bits equal.
- Push and pop in the same cycle: both happen and the level is unchanged. When full, a push cannot occur because s_ready is low, but a pop proceeds.
- Pop on an empty FIFO is impossible because m_valid=0.
- m_word/m_count are a combinational read of the head entry and are driven 0 when m_valid=0.
- Reset values: s_ready=1, m_valid=0, m_word=0, m_count=0, fifo_level=0, xz_seen=0, assembler EMPTY, all FIFO storage 0.
- Reset asserted mid-operation discards both the partial word and the FIFO contents immediately, asynchronously.

## Timing
- Throughput: one symbol per cycle; one full word every LANES cycles at sustained rate.
- Latency: a word whose final symbol is accepted at edge N shows m_valid=1 after edge N.
- No combinational path from s_valid/s_sym to m_*. Only fifo_level drives s_ready.
- Once a word is popped from a full FIFO at edge N, s_ready rises after edge N.
- fifo_level updates on the same edge as the push/pop that changes it.

## Configuration
- XZ_SCRUB_EN defined:
  - each accepted s_sym bit that is X or Z (4-state compare) is stored as 0;
  - xz_seen sets on the accepting edge and stays set until reset.
- XZ_SCRUB_EN undefined:
  - symbols are stored unmodified, so X/Z propagates to m_word;
  - xz_seen is tied 0.

## Test plan
- Full word (LANES=5, SYM_W=2): symbols 3,2,1,0,3 with s_last=0 and m_ready=1 → one cycle after the 5th accept, m_valid=1, m_word=10'h393, m_count=5.
- Flush: symbols 1, then 2 with s_last=1 → m_word=10'h180, m_count=2. A following symbol 3 with s_last=1 → m_word=10'h300, m_count=1.
- Backpressure: m_ready=0, feed 20 symbols continuously → fifo_level=4 and s_ready=0 after the 20th accept; the 21st symbol stalls. Assert m_ready for 1 cycle → fifo_level=3, s_ready=1 next cycle, and the 21st symbol is accepted. Words drain in order.
- Simultaneous push/pop: m_ready=1 with fifo_level=2 and a word completing → fifo_level stays 2, and the head advances.
- X-scrub: symbol 2'bx1 then four 0s, with XZ_SCRUB_EN defined → m_word=10'h100, xz_seen=1 sticky. Without the macro: m_word[9]=x and xz_seen=0.
- Reset mid-word: accept 3 symbols plus 2 queued words, then pulse rst_n low → m_valid=0, fifo_level=0, s_ready=1 immediately. After release, symbols 1,1,1,1,1 → m_word=10'h155, m_count=5.
